debug_tx_word_sender: RTL and testbench



---
 rtl/debug_tx_pkg.sv | 18 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/debug_tx_word_sender.sv | 151 +++++++++++++++
 tb/tb_debug_tx_word_sender.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_tx_pkg.sv
// rtl/debug_tx_pkg.sv - shared constants and FSM encoding for the debug TX word sender
package debug_tx_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] END_DATA_WORD = 32'h656E6464;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CHK   = 2'd3;

    function automatic logic [BYTE_W-1:0] msb_byte(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word fall-through head, push+pop allowed when full
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop frees the slot this same edge, so a full FIFO can still take a push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{ADDR_WIDTH{1'b0}}, do_push} - {{ADDR_WIDTH{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/debug_tx_word_sender.sv
// rtl/debug_tx_word_sender.sv - buffers 32-bit debug words and sends them MSB-first as bytes; DBG_TX_CHECKSUM_EN adds XOR byte after "endd"
module debug_tx_word_sender
    import debug_tx_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = 5,
    parameter int WORD_BYTES      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_write_en,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_tx_start,
    output logic [BYTE_W-1:0] o_tx_data,
    input  logic              i_tx_done,
    output logic              o_busy
);

    localparam logic [FIFO_ADDR_WIDTH:0] FIFO_DEPTH = (FIFO_ADDR_WIDTH+1)'(1 << FIFO_ADDR_WIDTH);

    logic [1:0]               state;
    logic [WORD_W-1:0]        shreg;
    logic [1:0]               byte_cnt;
    logic                     tx_start_q;
    logic [BYTE_W-1:0]        tx_data_q;
    logic                     overflow_q;

    logic [WORD_W-1:0]        fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_ADDR_WIDTH:0] fifo_count;
    logic                     fifo_pop;

    logic                     done_wait;
    logic                     word_last;
    logic                     go_chk;
    logic                     chk_done;
    logic [BYTE_W-1:0]        chk_byte;

    sync_fifo #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (i_write_en),
        .push_data (i_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign done_wait = (state == ST_WAIT) && i_tx_done;
    assign word_last = (byte_cnt == 2'(WORD_BYTES - 1));

`ifdef DBG_TX_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_xor;
    logic              is_end;

    assign go_chk   = done_wait && word_last && is_end;
    // The first CHK cycle carries the start pulse, so a done there is not ours.
    assign chk_done = (state == ST_CHK) && i_tx_done && !tx_start_q;
    assign chk_byte = chk_xor ^ tx_data_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            chk_xor <= '0;
            is_end  <= 1'b0;
        end else begin
            if (chk_done) begin
                chk_xor <= '0;
            end else if (done_wait) begin
                chk_xor <= chk_xor ^ tx_data_q;
            end
            if (fifo_pop) begin
                is_end <= (fifo_head == END_DATA_WORD);
            end
        end
    end
`else
    assign go_chk   = 1'b0;
    assign chk_done = 1'b0;
    assign chk_byte = '0;
`endif

    // Pop from IDLE, or straight after a finished word/checksum so words go back-to-back.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) || (done_wait && word_last && !go_chk) || chk_done);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            byte_cnt   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (i_write_en && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
            case (state)
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (!word_last) begin
                            byte_cnt   <= byte_cnt + 1'b1;
                            shreg      <= shreg << BYTE_W;
                            tx_data_q  <= shreg[WORD_W-BYTE_W-1 -: BYTE_W];
                            tx_start_q <= 1'b1;
                            state      <= ST_START;
                        end else if (go_chk) begin
                            tx_data_q  <= chk_byte;
                            tx_start_q <= 1'b1;
                            state      <= ST_CHK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_CHK: begin
                    if (chk_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Loading a new word overrides any IDLE transition chosen above.
            if (fifo_pop) begin
                shreg      <= fifo_head;
                tx_data_q  <= msb_byte(fifo_head);
                byte_cnt   <= '0;
                tx_start_q <= 1'b1;
                state      <= ST_START;
            end
        end
    end

    assign o_full     = (fifo_count == FIFO_DEPTH);
    assign o_empty    = fifo_empty;
    assign o_overflow = overflow_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_tx_word_sender.sv
// tb/tb_debug_tx_word_sender.sv - scoreboard bench for debug_tx_word_sender with a UART TX responder
module tb_debug_tx_word_sender;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_write_en;
    logic [31:0] i_data;
    logic        o_full, o_empty, o_overflow, o_tx_start, o_busy;
    logic [7:0]  o_tx_data;
    logic        tx_done;
    logic        rsp_done;
    logic        man_done;
    bit          manual = 1'b0;
    bit          rand_delay = 1'b0;
    int          delay = 3;

    always #5 clk = ~clk;

    assign tx_done = manual ? man_done : rsp_done;

    debug_tx_word_sender #(.FIFO_ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_write_en (i_write_en),
        .i_data     (i_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_done  (tx_done),
        .o_busy     (o_busy)
    );

    typedef struct packed {
        logic       first;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         start_cnt = 0;
    int         words_started = 0;
    int         model_bytes = 0;
    logic [7:0] model_xor = 8'h00;
    logic [7:0] last_byte = 8'h00;
    logic       prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: a word becomes four bytes, most significant first; "endd" closes a checksum block.
    task automatic model_push(input logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'((w >> (24 - 8 * i)) & 32'hFF);
            exp_q.push_back({(i == 0), b});
            model_xor = model_xor ^ b;
            model_bytes++;
        end
`ifdef DBG_TX_CHECKSUM_EN
        if (w == 32'h656E6464) begin
            exp_q.push_back({1'b0, model_xor});
            model_xor = 8'h00;
            model_bytes++;
        end
`endif
    endtask

    // Monitor: every start pulse must carry the next expected byte.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_tx_start) begin
                check("start_pulse_width", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_tx_byte: got %0h, required none", o_tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_byte", 32'(o_tx_data), 32'(mon_e.b));
                    if (mon_e.first) words_started++;
                end
                start_cnt++;
                last_byte = o_tx_data;
            end else if (o_busy) begin
                check("tx_data_stable", 32'(o_tx_data), 32'(last_byte));
            end
        end
        prev_start = o_tx_start;
    end

    // UART TX responder: done pulse a fixed or random number of cycles after each start.
    initial begin
        bit pending;
        int cnt;
        int cur_delay;
        pending = 1'b0;
        cnt = 0;
        cur_delay = 1;
        rsp_done = 1'b0;
        forever begin
            @(negedge clk);
            rsp_done = 1'b0;
            if (i_reset) begin
                pending = 1'b0;
            end else if (o_tx_start) begin
                pending = 1'b1;
                cnt = 0;
                cur_delay = rand_delay ? int'($urandom_range(1, 4)) : delay;
            end else if (pending && !manual) begin
                cnt++;
                if (cnt >= cur_delay) begin
                    pending = 1'b0;
                    rsp_done = 1'b1;
                end
            end
        end
    end

    task automatic push_cycle(input logic [31:0] w, input bit acc);
        i_write_en = 1'b1;
        i_data = w;
        if (acc) model_push(w);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_write_en = 1'b0;
        exp_q.delete();
        model_xor = 8'h00;
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic wait_start(input int n);
        int t;
        t = 0;
        while (start_cnt < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("wait_start", 32'(start_cnt >= n), 32'd1);
    endtask

    task automatic drain(input string name, input int base, input int nbytes, input bit gap_chk);
        int t;
        int gaps;
        t = 0;
        gaps = 0;
        while ((exp_q.size() != 0 || o_busy || !o_empty) && t < 3000) begin
            @(negedge clk);
            t++;
            if (gap_chk && exp_q.size() != 0 && start_cnt > base && !o_busy) gaps++;
        end
        check({name, "_timeout"}, 32'(t < 3000), 32'd1);
        check({name, "_bytes"}, 32'(start_cnt - base), 32'(nbytes));
        check({name, "_empty"}, 32'(o_empty), 32'd1);
        check({name, "_busy"}, 32'(o_busy), 32'd0);
        if (gap_chk) check({name, "_idle_gaps"}, 32'(gaps), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1);
    end

    initial begin
        int base;
        int mbase;
        int acc;
        int ws0;
        logic [31:0] w;
        i_reset = 1'b1;
        i_write_en = 1'b0;
        i_data = '0;
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        @(negedge clk);

        base = start_cnt;
        push_cycle(32'h11223344, 1'b1);
        i_write_en = 1'b0;
        @(negedge clk);
        check("latency_start", 32'(o_tx_start), 32'd1);
        drain("single", base, 4, 1'b0);

        base = start_cnt;
        push_cycle(32'hA0A1A2A3, 1'b1);
        push_cycle(32'hB0B1B2B3, 1'b1);
        push_cycle(32'hC0C1C2C3, 1'b1);
        i_write_en = 1'b0;
        drain("burst3", base, 12, 1'b1);
        check("burst3_overflow", 32'(o_overflow), 32'd0);

        base = start_cnt;
        push_cycle(32'h01020304, 1'b1);
        push_cycle(32'h656E6464, 1'b1);
        i_write_en = 1'b0;
`ifdef DBG_TX_CHECKSUM_EN
        drain("endd", base, 9, 1'b0);
`else
        drain("endd", base, 8, 1'b0);
`endif

        // One word sits in the serializer, four fill the FIFO, the sixth is dropped.
        do_reset();
        manual = 1'b1;
        base = start_cnt;
        for (int i = 0; i < 6; i++) push_cycle(32'h10000000 * (i + 1) + 32'h00112233, (i < 5));
        i_write_en = 1'b0;
        check("stall_full", 32'(o_full), 32'd1);
        check("stall_overflow", 32'(o_overflow), 32'd1);
        check("stall_busy", 32'(o_busy), 32'd1);
        manual = 1'b0;
        drain("stall", base, 20, 1'b0);

        do_reset();
        manual = 1'b1;
        base = start_cnt;
        for (int i = 0; i < 5; i++) push_cycle(32'h0F0E0D00 + 32'(i), 1'b1);
        i_write_en = 1'b0;
        check("pp_full_before", 32'(o_full), 32'd1);
        for (int k = 0; k < 3; k++) begin
            man_done = 1'b1;
            @(negedge clk);
            man_done = 1'b0;
            @(negedge clk);
        end
        man_done = 1'b1;
        i_write_en = 1'b1;
        i_data = 32'hDEADBEEF;
        model_push(32'hDEADBEEF);
        @(negedge clk);
        man_done = 1'b0;
        i_write_en = 1'b0;
        check("pp_full_after", 32'(o_full), 32'd1);
        check("pp_overflow", 32'(o_overflow), 32'd0);
        manual = 1'b0;
        drain("pushpop", base, 24, 1'b0);

        do_reset();
        delay = 4;
        base = start_cnt;
        push_cycle(32'hA1B2C3D4, 1'b1);
        i_write_en = 1'b0;
        wait_start(base + 2);
        @(negedge clk);
        i_reset = 1'b1;
        exp_q.delete();
        model_xor = 8'h00;
        @(negedge clk);
        i_reset = 1'b0;
        check("midrst_tx_start", 32'(o_tx_start), 32'd0);
        check("midrst_empty", 32'(o_empty), 32'd1);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_tx_data", 32'(o_tx_data), 32'd0);
        base = start_cnt;
        push_cycle(32'h5A6B7C8D, 1'b1);
        i_write_en = 1'b0;
        drain("after_rst", base, 4, 1'b0);

        rand_delay = 1'b1;
        base = start_cnt;
        mbase = model_bytes;
        acc = 0;
        ws0 = words_started;
        for (int c = 0; c < 4000 && acc < 40; c++) begin
            if ($urandom_range(0, 2) == 0 && (acc - (words_started - ws0)) < DEPTH) begin
                w = $urandom;
                push_cycle(w, 1'b1);
                acc++;
            end else begin
                i_write_en = 1'b0;
                @(negedge clk);
            end
        end
        i_write_en = 1'b0;
        check("rand_pushed", 32'(acc), 32'd40);
        drain("random", base, model_bytes - mbase, 1'b0);
        check("rand_overflow", 32'(o_overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
